// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press/release/long/repeat events.
// The state is visible on dbg_state for external checkers.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_in,
  input  logic       enable,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam bit               REPEAT_ON   = (REPEAT_CYCLES != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             rise;

  assign rise = button_in & ~btn_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_d     = button_in;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (!enable) begin
      // Aborted presses are dropped silently; btn_q keeps tracking so a held
      // level does not look like a fresh edge once enable returns.
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = CNT_ZERO;
          if (rise) begin
            state_d = PRESS;
            press_d = 1'b1;
          end
        end
        PRESS: begin
          if (!button_in) begin
            state_d   = IDLE;
            cnt_d     = CNT_ZERO;
            release_d = 1'b1;
          end else if (cnt_q == LONG_LAST) begin
            state_d = HOLD;
            cnt_d   = CNT_ZERO;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HOLD: begin
          if (!button_in) begin
            state_d   = IDLE;
            cnt_d     = CNT_ZERO;
            release_d = 1'b1;
          end else if (REPEAT_ON && (cnt_q == REPEAT_LAST)) begin
            cnt_d    = CNT_ZERO;
            repeat_d = 1'b1;
          end else if (REPEAT_ON) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign dbg_state     = state_q;

  pulses_exclusive_a : assert property (@(posedge clk) disable iff (!reset)
    $onehot0({press_q, release_q, long_q, repeat_q}));

endmodule
